// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. Owns the PC register, issues
//               instruction fetches with a bounded wait for imem_ready,
//               presents the fetched instruction to the datapath and selects
//               the next PC (sequential, branch, jump, stall or halt).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               halt,
    input  logic               jump,
    input  logic [PC_W-3:0]    jump_target,
    input  logic               branch_taken,
    input  logic [PC_W-3:0]    branch_offset,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4,
    output logic [7:0]         retire_count,
    output logic               halted,
    output logic               err
);

    // Wait counter only has to reach TIMEOUT-1 (last allowed FETCH cycle).
    localparam int              c_CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_EXEC  = 3'd2;
    localparam logic [2:0] c_ST_HALT  = 3'd3;
    localparam logic [2:0] c_ST_ERR   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [7:0]         r_retire;
    logic [7:0]         w_retire_nxt;
    logic [c_CNT_W-1:0] r_wait;
    logic [c_CNT_W-1:0] w_wait_nxt;

    logic [PC_W-1:0]    w_pc_seq;
    logic [PC_W-1:0]    w_pc_branch;
    logic [PC_W-1:0]    w_pc_jump;

    // Candidate next-PC values. Sign-extending the word offset and shifting
    // left by two, then truncating to PC_W bits, is exactly {offset, 2'b00},
    // so modulo-2^PC_W arithmetic falls out of the natural adder width.
    assign w_pc_seq    = r_pc + PC_W'(4);
    assign w_pc_branch = w_pc_seq + {branch_offset, 2'b00};
    assign w_pc_jump   = {jump_target, 2'b00};

    // State, PC, instruction, retire counter and fetch-wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_retire <= '0;
            r_wait   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_instr  <= w_instr_nxt;
            r_retire <= w_retire_nxt;
            r_wait   <= w_wait_nxt;
        end
    end

    // Next-state and next-register logic; every register holds by default.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_instr_nxt  = r_instr;
        w_retire_nxt = r_retire;
        w_wait_nxt   = r_wait;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end

            c_ST_FETCH: begin
                // Ready is checked first so it wins on the last allowed cycle.
                if (imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_wait_nxt  = '0;
                    w_state_nxt = c_ST_EXEC;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = c_ST_ERR;
                end else begin
                    w_wait_nxt  = r_wait + c_CNT_W'(1);
                end
            end

            c_ST_EXEC: begin
                // A stalled instruction freezes everything, controls included.
                if (!stall) begin
                    w_retire_nxt = r_retire + 8'd1;
                    if (halt) begin
                        w_state_nxt = c_ST_HALT;
                    end else if (jump) begin
                        w_pc_nxt    = w_pc_jump;
                        w_state_nxt = c_ST_FETCH;
                    end else if (branch_taken) begin
                        w_pc_nxt    = w_pc_branch;
                        w_state_nxt = c_ST_FETCH;
                    end else begin
                        w_pc_nxt    = w_pc_seq;
                        w_state_nxt = c_ST_FETCH;
                    end
                end
            end

            // HALT and ERR are terminal until reset.
            c_ST_HALT: begin
                w_state_nxt = c_ST_HALT;
            end

            c_ST_ERR: begin
                w_state_nxt = c_ST_ERR;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registers, so an asynchronous reset
    // clears them without waiting for a clock edge.
    assign imem_req     = (r_state == c_ST_FETCH);
    assign imem_addr    = r_pc;
    assign instr        = r_instr;
    assign instr_valid  = (r_state == c_ST_EXEC);
    assign pc           = r_pc;
    assign pc_plus4     = w_pc_seq;
    assign retire_count = r_retire;
    assign halted       = (r_state == c_ST_HALT);
    assign err          = (r_state == c_ST_ERR);

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that owns and sequences the 8-bit program counter register of the processor.
- Issues instruction-fetch requests to instruction memory and waits for a ready handshake, with a timeout.
- Presents the fetched instruction to the datapath, then selects the next PC: sequential, branch, jump, stall or halt.
- Sits between instruction memory and the decode/execute datapath; replaces the free-running PC update.

Parameters:
- PC_W, 8: PC width in bits; byte address, word-aligned; arithmetic modulo 2^PC_W.
- INSTR_W, 32: instruction width.
- RESET_PC, 8'h00: PC value loaded on reset.
- TIMEOUT, 15: maximum FETCH cycles waiting for imem_ready before entering ERR; must be ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- instr  out  INSTR_W  registered instruction for the datapath.
- instr_valid  out  1  instr is valid; high only in EXEC.
- stall  in  1  hold the current instruction (sampled in EXEC).
- halt  in  1  current instruction is HALT.
- jump  in  1  take a jump.
- jump_target  in  PC_W-2  word index of the jump target.
- branch_taken  in  1  take a branch.
- branch_offset  in  PC_W-2  signed word offset for the branch.
- pc  out  PC_W  current PC register.
- pc_plus4  out  PC_W  combinational pc+4, modulo 2^PC_W.
- retire_count  out  8  count of retired instructions; wraps.
- halted  out  1  FSM is in HALT.
- err  out  1  FSM is in ERR (fetch timeout).

Behaviour:
- Reset, asynchronous and at any time including mid-fetch:
  - state=IDLE, pc=RESET_PC, instr=0, retire_count=0, wait counter=0.
  - All outputs low, except pc (=RESET_PC) and pc_plus4 (=RESET_PC+4).
- States: IDLE, FETCH, EXEC, HALT, ERR.
- IDLE:
  - start=1 → FETCH next cycle.
  - Otherwise remain in IDLE; no request issued.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ready=1 → instr<=imem_rdata, wait counter<=0, state→EXEC. instr_valid rises the next cycle.
  - imem_ready=0 and wait counter==TIMEOUT-1 → ERR.
  - Otherwise wait counter increments.
  - If imem_ready=1 arrives on the final allowed cycle, the ready wins.
  - Fetch latency with zero-wait memory: 1 cycle in FETCH.
- EXEC:
  - instr_valid=1; next-PC inputs are evaluated every EXEC cycle.
  - stall=1 → remain in EXEC. pc, instr and retire_count are unchanged, and all control inputs are ignored.
  - stall=0 → retire_count+1 (mod 256). Then apply the first matching rule, by priority halt > jump > branch > sequential:
    - halt: pc unchanged, state→HALT.
    - jump: pc<={jump_target,2'b00}, state→FETCH.
    - branch_taken: pc<=pc+4+(sign_extend(branch_offset)<<2), mod 2^PC_W, state→FETCH.
    - else: pc<=pc+4, mod 2^PC_W (0xFC→0x00), state→FETCH.
- HALT: halted=1 and stays until rst; start and all control inputs are ignored.
- ERR: err=1 and stays until rst; pc holds the address that timed out.
- Minimum steady-state throughput: one instruction per 2 cycles (FETCH+EXEC).
- pc changes only on an EXEC exit or on reset.

Test Plan:
- Basic sequencing: rst, then start=1 for 1 cycle, zero-wait memory returning 32'h1111_0000+addr.
  - imem_addr sequence 0x00, 0x04, 0x08.
  - instr_valid high every other cycle; retire_count 1, 2, 3.
- Ready delay and stall:
  - imem_ready delayed 2 cycles → req held for 3 cycles, instr captured correctly.
  - stall=1 for 3 EXEC cycles → pc and instr unchanged, retire_count unchanged until stall drops.
- Branch and wrap:
  - pc=0x10, branch_offset=6'h3F (-1) → next fetch 0x10.
  - branch_offset=6'h02 → next fetch 0x1C.
  - pc=0xFC, sequential → 0x00.
- Priority: halt=jump=branch_taken=1 at pc=0x20 → HALT, halted=1, pc=0x20.
  - Later start=1 has no effect.
  - jump=branch_taken=1 with jump_target=6'h3F → pc=0xFC.
- Timeout (TIMEOUT=4), imem_ready held 0:
  - ERR entered after 4 FETCH cycles, err=1, imem_req=0.
  - A second run with imem_ready=1 on the 4th FETCH cycle → EXEC, no err.
- Reset mid-operation: rst asserted mid-FETCH (asynchronously, between edges) → outputs clear immediately, pc=RESET_PC, state IDLE; restart on start works.
